bias_add_scheduler: RTL and testbench

- Sequences one shared vector adder (LENGTH lanes of Floating_point_Unit, add mode) over a multi-tile vector held in on-chip buffers.
- Per tile: reads an x tile and a bias tile, holds the adder enabled for its fixed latency, then writes the result tile to a destination buffer.
- Sits between the layer controller (start/done) and the bias-add datapath; one tile in flight at a time.

---
 rtl/bias_add_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_bias_add_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_add_scheduler.sv
// Tile scheduler for a shared LENGTH-lane vector adder.
// Walks x/bias tiles through read, operand load, add hold and result write.
module bias_add_scheduler #(
  parameter int DATA_WIDTH  = 16,
  parameter int LENGTH      = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int ADD_LATENCY = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        x_base,
  input  logic [ADDR_WIDTH-1:0]        bias_base,
  input  logic [ADDR_WIDTH-1:0]        dst_base,
  input  logic [ADDR_WIDTH-1:0]        num_tiles,
  output logic                         busy,
  output logic                         done,
  output logic                         x_rd_en,
  output logic                         bias_rd_en,
  output logic [ADDR_WIDTH-1:0]        x_rd_addr,
  output logic [ADDR_WIDTH-1:0]        bias_rd_addr,
  input  logic [LENGTH*DATA_WIDTH-1:0] x_rd_data,
  input  logic [LENGTH*DATA_WIDTH-1:0] bias_rd_data,
  output logic                         add_en,
  output logic [LENGTH*DATA_WIDTH-1:0] add_x,
  output logic [LENGTH*DATA_WIDTH-1:0] add_bias,
  input  logic [LENGTH*DATA_WIDTH-1:0] add_out,
  output logic                         wr_en,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic [LENGTH*DATA_WIDTH-1:0] wr_data
);

  localparam int VW = LENGTH * DATA_WIDTH;
  localparam int CW = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ADD_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_ADD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] xb_q;
  logic [ADDR_WIDTH-1:0] bb_q;
  logic [ADDR_WIDTH-1:0] db_q;
  logic [ADDR_WIDTH-1:0] n_q;
  logic [ADDR_WIDTH-1:0] t_q;
  logic [CW-1:0]         cnt_q;

  logic                  busy_q;
  logic                  done_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] x_addr_q;
  logic [ADDR_WIDTH-1:0] b_addr_q;
  logic                  add_en_q;
  logic [VW-1:0]         add_x_q;
  logic [VW-1:0]         add_b_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;

  logic [ADDR_WIDTH-1:0] t_d;
  logic                  last_tile;

  assign t_d       = t_q + ONE;
  assign last_tile = (t_q == (n_q - ONE));

  // Outputs are registered alongside the state they belong to,
  // so every strobe is computed for the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      xb_q      <= '0;
      bb_q      <= '0;
      db_q      <= '0;
      n_q       <= '0;
      t_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      x_addr_q  <= '0;
      b_addr_q  <= '0;
      add_en_q  <= 1'b0;
      add_x_q   <= '0;
      add_b_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      x_addr_q  <= '0;
      b_addr_q  <= '0;
      add_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            xb_q <= x_base;
            bb_q <= bias_base;
            db_q <= dst_base;
            n_q  <= num_tiles;
            t_q  <= '0;
            if (num_tiles == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q  <= S_READ;
              busy_q   <= 1'b1;
              rd_en_q  <= 1'b1;
              x_addr_q <= x_base;
              b_addr_q <= bias_base;
            end
          end
        end
        S_READ: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          add_x_q  <= x_rd_data;
          add_b_q  <= bias_rd_data;
          cnt_q    <= '0;
          add_en_q <= 1'b1;
          state_q  <= S_ADD;
        end
        S_ADD: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= db_q + t_q;
            state_q   <= S_WRITE;
          end else begin
            cnt_q    <= cnt_q + 1'b1;
            add_en_q <= 1'b1;
          end
        end
        S_WRITE: begin
          if (last_tile) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            t_q      <= t_d;
            state_q  <= S_READ;
            rd_en_q  <= 1'b1;
            x_addr_q <= xb_q + t_d;
            b_addr_q <= bb_q + t_d;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign x_rd_en      = rd_en_q;
  assign bias_rd_en   = rd_en_q;
  assign x_rd_addr    = x_addr_q;
  assign bias_rd_addr = b_addr_q;
  assign add_en       = add_en_q;
  assign add_x        = add_x_q;
  assign add_bias     = add_b_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  // Adder result is forwarded straight to the buffer during WRITE.
  assign wr_data      = wr_en_q ? add_out : '0;

endmodule

// File: tb/tb_bias_add_scheduler.sv
// Bench for bias_add_scheduler: buffer and fp16 adder models plus
// a per-cycle timing/data reference derived from tile arithmetic.
module tb_bias_add_scheduler;

  localparam int DW = 16;
  localparam int L  = 4;
  localparam int AW = 8;
  localparam int AL = 3;
  localparam int VW = L * DW;
  localparam int TC = AL + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] x_base, bias_base, dst_base, num_tiles;
  logic          busy, done;
  logic          x_rd_en, bias_rd_en;
  logic [AW-1:0] x_rd_addr, bias_rd_addr;
  logic [VW-1:0] x_rd_data, bias_rd_data;
  logic          add_en;
  logic [VW-1:0] add_x, add_bias, add_out;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [VW-1:0] wr_data;

  int vectors = 0;
  int miscompares = 0;

  logic [VW-1:0] x_mem [256];
  logic [VW-1:0] b_mem [256];
  int xi [256][L];
  int bi [256][L];

  always #5 clk = ~clk;

  bias_add_scheduler #(
    .DATA_WIDTH(DW), .LENGTH(L), .ADDR_WIDTH(AW), .ADD_LATENCY(AL)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .x_base(x_base), .bias_base(bias_base), .dst_base(dst_base),
    .num_tiles(num_tiles), .busy(busy), .done(done),
    .x_rd_en(x_rd_en), .bias_rd_en(bias_rd_en),
    .x_rd_addr(x_rd_addr), .bias_rd_addr(bias_rd_addr),
    .x_rd_data(x_rd_data), .bias_rd_data(bias_rd_data),
    .add_en(add_en), .add_x(add_x), .add_bias(add_bias),
    .add_out(add_out), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  function automatic int h2i(input logic [15:0] h);
    int e, v;
    if (h[14:0] == 15'd0) return 0;
    e = int'(h[14:10]);
    v = 1024 + int'(h[9:0]);
    if (e >= 25) return v << (e - 25);
    return v >> (25 - e);
  endfunction

  function automatic logic [15:0] i2h(input int n);
    int p;
    logic [15:0] h;
    if (n == 0) return 16'h0000;
    p = 0;
    for (int b = 0; b < 11; b++) if ((n >> b) & 1) p = b;
    h[15]    = 1'b0;
    h[14:10] = 5'(p + 15);
    h[9:0]   = 10'((n << (10 - p)) & 32'h3FF);
    return h;
  endfunction

  always @(posedge clk) begin
    x_rd_data <= x_rd_en ? x_mem[x_rd_addr] : {$urandom, $urandom};
    bias_rd_data <= bias_rd_en ? b_mem[bias_rd_addr] : {$urandom, $urandom};
  end

  int acnt = 0;
  initial add_out = '0;
  always @(posedge clk) begin
    if (add_en) begin
      if (acnt == AL - 1) begin
        for (int l = 0; l < L; l++)
          add_out[l*DW +: DW] <= i2h(h2i(add_x[l*DW +: DW]) + h2i(add_bias[l*DW +: DW]));
        acnt <= 0;
      end else begin
        acnt <= acnt + 1;
      end
    end else begin
      acnt <= 0;
    end
  end

  initial begin
    #1_000_000;
    miscompares++;
    $error("FAIL watchdog: wait expired before test completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic chk(input string tag, input bit ok,
                     input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] ref_sum(input int xa, input int ba);
    logic [VW-1:0] r;
    for (int l = 0; l < L; l++) r[l*DW +: DW] = i2h(xi[xa][l] + bi[ba][l]);
    return r;
  endfunction

  task automatic set_tile(input int a, input int xv, input int bv);
    for (int l = 0; l < L; l++) begin
      xi[a][l] = xv;
      bi[a][l] = bv;
      x_mem[a][l*DW +: DW] = i2h(xv);
      b_mem[a][l*DW +: DW] = i2h(bv);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".busy"}, busy === 1'b0, busy, 0);
    chk({tag, ".done"}, done === 1'b0, done, 0);
    chk({tag, ".rd_en"}, (x_rd_en | bias_rd_en) === 1'b0,
        x_rd_en | bias_rd_en, 0);
    chk({tag, ".add_en"}, add_en === 1'b0, add_en, 0);
    chk({tag, ".wr_en"}, wr_en === 1'b0, wr_en, 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check_quiet(tag);
    chk({tag, ".addr"}, {x_rd_addr, bias_rd_addr, wr_addr} === 24'h0,
        {x_rd_addr, bias_rd_addr, wr_addr}, 0);
    chk({tag, ".ops"}, {add_x, add_bias} === 128'h0,
        {add_x, add_bias}, 0);
    chk({tag, ".wdata"}, wr_data === 64'h0, wr_data, 0);
    repeat (3) begin
      @(negedge clk);
      check_quiet(tag);
    end
    reset = 1'b1;
    @(negedge clk);
    check_quiet({tag, ".post"});
  endtask

  task automatic run_job(input string tag, input logic [AW-1:0] xb,
                         input logic [AW-1:0] bb, input logic [AW-1:0] db,
                         input int n, input int start_k, input int abort_k);
    int total;
    int tl, ph;
    bit act, e_rd, e_add, e_wr, e_dn;
    logic [AW-1:0] ea;
    logic [VW-1:0] ev;
    int wr_seen;
    string p;
    total = n * TC + 1;
    wr_seen = 0;
    @(negedge clk);
    x_base = xb; bias_base = bb; dst_base = db;
    num_tiles = AW'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x_base = 8'hAA; bias_base = 8'h55; dst_base = 8'h3C; num_tiles = 8'h7;
    for (int k = 1; k <= total + 1; k++) begin
      tl = (k - 1) / TC;
      ph = (k - 1) % TC;
      act = (k <= n * TC);
      e_rd = act && ph == 0;
      e_add = act && ph >= 2 && ph <= AL + 1;
      e_wr = act && ph == AL + 2;
      e_dn = (k == total);
      p = $sformatf("%s.c%0d", tag, k);
      chk({p, ".busy"}, busy === act, busy, act);
      chk({p, ".done"}, done === e_dn, done, e_dn);
      chk({p, ".xrd"}, x_rd_en === e_rd, x_rd_en, e_rd);
      chk({p, ".brd"}, bias_rd_en === e_rd, bias_rd_en, e_rd);
      ea = e_rd ? AW'(int'(xb) + tl) : '0;
      chk({p, ".xaddr"}, x_rd_addr === ea, x_rd_addr, ea);
      ea = e_rd ? AW'(int'(bb) + tl) : '0;
      chk({p, ".baddr"}, bias_rd_addr === ea, bias_rd_addr, ea);
      chk({p, ".add_en"}, add_en === e_add, add_en, e_add);
      chk({p, ".wr_en"}, wr_en === e_wr, wr_en, e_wr);
      ea = e_wr ? AW'(int'(db) + tl) : '0;
      chk({p, ".waddr"}, wr_addr === ea, wr_addr, ea);
      if (e_add) begin
        ev = x_mem[(int'(xb) + tl) % 256];
        chk({p, ".add_x"}, add_x === ev, add_x, ev);
        ev = b_mem[(int'(bb) + tl) % 256];
        chk({p, ".add_b"}, add_bias === ev, add_bias, ev);
      end
      if (e_wr) begin
        wr_seen++;
        ev = ref_sum((int'(xb) + tl) % 256, (int'(bb) + tl) % 256);
        chk({p, ".wdata"}, wr_data === ev, wr_data, ev);
      end
      if (k == abort_k) begin
        do_reset({tag, ".abort"});
        return;
      end
      if (k == start_k) begin
        x_base = 8'h01; num_tiles = 8'h01; start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk({tag, ".writes"}, wr_seen == n, wr_seen, n);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0;
    x_base = '0; bias_base = '0; dst_base = '0; num_tiles = '0;
    for (int a = 0; a < 256; a++)
      set_tile(a, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || x_rd_en !== 1'b0 ||
        bias_rd_en !== 1'b0 || add_en !== 1'b0 || wr_en !== 1'b0 ||
        wr_data !== '0) begin
      miscompares++;
      $error("FAIL rst.state: outputs not zero during reset");
    end
    check_quiet("rst");
    chk("rst.ops", {add_x, add_bias} === 128'h0, {add_x, add_bias}, 0);
    chk("rst.addr", {x_rd_addr, bias_rd_addr, wr_addr} === 24'h0,
        {x_rd_addr, bias_rd_addr, wr_addr}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    set_tile(8'h05, 1, 2);
    run_job("one", 8'h05, 8'h05, 8'h09, 1, -1, -1);
    chk("one.sum", ref_sum(5, 5) === 64'h4200_4200_4200_4200,
        ref_sum(5, 5), 64'h4200_4200_4200_4200);

    run_job("three", 8'h10, 8'h20, 8'h30, 3, -1, -1);
    run_job("zero", 8'h10, 8'h20, 8'h30, 0, -1, -1);
    run_job("wrap", 8'hFE, 8'h40, 8'hFF, 3, -1, -1);
    run_job("busy_start", 8'h50, 8'h60, 8'h70, 3, 4, -1);
    run_job("abort", 8'h50, 8'h60, 8'h70, 3, -1, 2 * TC - 2);
    run_job("after", 8'h80, 8'h90, 8'hA0, 2, -1, -1);

    for (int r = 0; r < 4; r++)
      run_job($sformatf("rnd%0d", r), AW'($urandom), AW'($urandom),
              AW'($urandom), int'($urandom_range(1, 6)), -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
